// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply (radix-2 Booth) / restoring divide into HI/LO.
// Optional feature macro MULTDIV_UNSIGNED_EN adds the is_unsigned port (multu/divu).
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_0
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_q1;
    logic             r_uns;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic             r_div_0;
    logic [CNT_W-1:0] r_cnt;

    logic             w_uns_in;
`ifdef MULTDIV_UNSIGNED_EN
    assign w_uns_in = is_unsigned;
`else
    assign w_uns_in = 1'b0;
`endif

    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_a_neg = !w_uns_in && a_in[WIDTH-1];
    assign w_b_neg = !w_uns_in && b_in[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a_in : a_in;
    assign w_b_mag = w_b_neg ? -b_in : b_in;

    // One multiply step; acc carries an extra bit so adding/subtracting the most negative multiplicand cannot overflow.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_mul_acc;
    logic [WIDTH-1:0] w_mul_q;

    always_comb begin
        w_mul_sum = r_acc;
        if (r_uns) begin
            if (r_q[0]) w_mul_sum = r_acc + r_m;
        end else if (r_q[0] && !r_q1) begin
            w_mul_sum = r_acc - r_m;
        end else if (!r_q[0] && r_q1) begin
            w_mul_sum = r_acc + r_m;
        end
        w_mul_acc = {(r_uns ? 1'b0 : w_mul_sum[WIDTH]), w_mul_sum[WIDTH:1]};
        w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end

    // One restoring-divide step on magnitudes, plus the sign fix-up applied on the final write.
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_div_rem;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    always_comb begin
        w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_trial  = w_rem_sh - r_m;
        if (w_trial[WIDTH]) begin
            w_div_rem = w_rem_sh;
            w_div_q   = {r_q[WIDTH-2:0], 1'b0};
        end else begin
            w_div_rem = w_trial;
            w_div_q   = {r_q[WIDTH-2:0], 1'b1};
        end
        w_q_fin = r_neg_q ? -w_div_q : w_div_q;
        w_r_fin = r_neg_r ? -w_div_rem[WIDTH-1:0] : w_div_rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_q1    <= 1'b0;
            r_uns   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div_0 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        r_cnt   <= '0;
                        r_div_0 <= 1'b0;
                        r_uns   <= w_uns_in;
                        r_acc   <= '0;
                        r_q1    <= 1'b0;
                        if (start_mult) begin
                            r_m     <= {w_a_neg, a_in};
                            r_q     <= b_in;
                            r_busy  <= 1'b1;
                            r_state <= MULT;
                        end else begin
                            r_m     <= {1'b0, w_b_mag};
                            r_q     <= w_a_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_busy  <= (b_in != '0);
                            r_state <= DIV;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_mul_acc;
                    r_q   <= w_mul_q;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_mul_acc[WIDTH-1:0];
                        r_lo    <= w_mul_q;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end
                end
                DIV: begin
                    // A zero divisor magnitude only arises from b_in==0: flag on the first edge, leave hi/lo alone.
                    if (r_m == '0) begin
                        r_div_0 <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_acc <= w_div_rem;
                        r_q   <= w_div_q;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_hi    <= w_r_fin;
                            r_lo    <= w_q_fin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign done  = r_done;
    assign div_0 = r_div_0;

endmodule
